// File: rtl/activation_pkg.sv
// Shared types and constants for the activation layer datapath.
// Q8.8 fixed-point samples by default.
package activation_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] CLIP_MAX_Q88 = 16'h0600;

  typedef logic signed [DATA_W_DEF-1:0] feat_t;

endpackage

// File: rtl/activation_fn.sv
// Combinational rectifier: plain, leaky and/or clipped ReLU.
// All arithmetic stays at DATA_W; no widening is needed.
module activation_fn
  import activation_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEAKY_SHIFT = 0,
  parameter int CLIP_EN = 0,
  parameter logic signed [DATA_W-1:0] CLIP_MAX =
    DATA_W'(CLIP_MAX_Q88)
) (
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);

  always_comb begin
    y = x;
    if (x[DATA_W-1]) begin
      // floor-rounded shift keeps negatives at -1 or below
      if (LEAKY_SHIFT == 0) y = '0;
      else y = x >>> LEAKY_SHIFT;
    end else if (CLIP_EN != 0 && x > CLIP_MAX) begin
      y = CLIP_MAX;
    end
  end

endmodule

// File: rtl/activation_pe_core.sv
// Single-lane activation PE: f(x) followed by one output register stage.
// Fixed 1-cycle latency so lane flags can be ANDed by the layer.
module activation_pe_core
  import activation_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEAKY_SHIFT = 0,
  parameter int CLIP_EN = 0,
  parameter logic signed [DATA_W-1:0] CLIP_MAX =
    DATA_W'(CLIP_MAX_Q88)
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] input_featuremap,
  output logic signed [DATA_W-1:0] output_featuremap,
  output logic                     flag
);

  logic signed [DATA_W-1:0] act;

  activation_fn #(
    .DATA_W     (DATA_W),
    .LEAKY_SHIFT(LEAKY_SHIFT),
    .CLIP_EN    (CLIP_EN),
    .CLIP_MAX   (CLIP_MAX)
  ) u_fn (
    .x(input_featuremap),
    .y(act)
  );

  // data only loads on enable, so idle X inputs never reach the outputs
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      output_featuremap <= '0;
      flag <= 1'b0;
    end else if (start) begin
      output_featuremap <= '0;
      flag <= 1'b0;
    end else if (enable) begin
      output_featuremap <= act;
      flag <= 1'b1;
    end else begin
      flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_activation_pe_core.sv
// Directed bench for activation_pe_core: default, clipped and leaky lanes
// share one stimulus stream.
module tb_activation_pe_core;
  import activation_pkg::*;

  logic clk = 1'b0;
  logic n_reset, start, enable;
  logic [15:0] din;

  logic [15:0] o_def, o_clip, o_leak;
  logic f_def, f_clip, f_leak;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  activation_pe_core u_def (
    .clk(clk), .n_reset(n_reset), .start(start),
    .enable(enable), .input_featuremap(din),
    .output_featuremap(o_def), .flag(f_def)
  );

  activation_pe_core #(.CLIP_EN(1)) u_clip (
    .clk(clk), .n_reset(n_reset), .start(start),
    .enable(enable), .input_featuremap(din),
    .output_featuremap(o_clip), .flag(f_clip)
  );

  activation_pe_core #(.LEAKY_SHIFT(2)) u_leak (
    .clk(clk), .n_reset(n_reset), .start(start),
    .enable(enable), .input_featuremap(din),
    .output_featuremap(o_leak), .flag(f_leak)
  );

  // mode 0 = plain, 1 = clip at 0x0600, 2 = leaky shift 2
  function automatic logic [15:0] model(int mode, logic [15:0] x);
    int xi;
    xi = $signed(x);
    if (xi >= 0) begin
      if (mode == 1 && xi > 1536) return 16'h0600;
      return x;
    end
    if (mode == 2) return 16'((xi - 3) / 4);
    return 16'h0000;
  endfunction

  task automatic chk(string tag, logic [15:0] obs,
                     logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_def(string tag, logic f, logic [15:0] o);
    chk({tag, "_flag"}, {15'b0, f_def}, {15'b0, f});
    chk({tag, "_out"}, o_def, o);
  endtask

  task automatic drive(logic e, logic [15:0] d);
    enable = e;
    din = d;
  endtask

  logic [15:0] vin [5];
  logic [15:0] vexp [5];
  logic pe;
  logic [15:0] pd;
  logic [15:0] hd, hc, hl;

  initial begin
    vin = '{16'h0234, 16'hFF00, 16'h0000, 16'h8000, 16'h7FFF};
    vexp = '{16'h0234, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
    n_reset = 1'b0;
    start = 1'b0;
    drive(1'b1, 16'h0100);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_def("reset", 1'b0, 16'h0000);
    end

    n_reset = 1'b1;
    tick();
    chk_def("first_en", 1'b1, 16'h0100);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vin[i]);
      tick();
      chk_def($sformatf("vec%0d", i), 1'b1, vexp[i]);
    end

    drive(1'b0, 16'h1234);
    tick();
    chk_def("idle", 1'b0, 16'h7FFF);

    drive(1'b1, 16'h0011);
    tick();
    chk_def("pat1", 1'b1, 16'h0011);
    drive(1'b1, 16'h0022);
    tick();
    chk_def("pat2", 1'b1, 16'h0022);
    drive(1'b0, 16'hxxxx);
    tick();
    chk_def("pat_gap", 1'b0, 16'h0022);
    chk("gap_leak_x", o_leak, 16'h0022);
    drive(1'b1, 16'h0033);
    tick();
    chk_def("pat4", 1'b1, 16'h0033);

    start = 1'b1;
    drive(1'b1, 16'h0500);
    tick();
    chk_def("start_drop", 1'b0, 16'h0000);
    start = 1'b0;

    drive(1'b1, 16'h0101);
    tick();
    chk_def("burst1", 1'b1, 16'h0101);
    drive(1'b1, 16'h0102);
    tick();
    chk_def("burst2", 1'b1, 16'h0102);
    start = 1'b1;
    drive(1'b1, 16'h0103);
    tick();
    chk_def("burst_cut", 1'b0, 16'h0000);
    start = 1'b0;
    drive(1'b1, 16'h0104);
    tick();
    chk_def("post_start", 1'b1, 16'h0104);

    n_reset = 1'b0;
    drive(1'b1, 16'h0105);
    tick();
    chk_def("mid_reset", 1'b0, 16'h0000);
    n_reset = 1'b1;

    drive(1'b1, 16'h0700);
    tick();
    chk("clip_0700", o_clip, 16'h0600);
    drive(1'b1, 16'h05FF);
    tick();
    chk("clip_05ff", o_clip, 16'h05FF);
    drive(1'b1, 16'h7FFF);
    tick();
    chk("clip_7fff", o_clip, 16'h0600);
    drive(1'b1, 16'hFF00);
    tick();
    chk("leak_ff00", o_leak, 16'hFFC0);
    chk("clip_ff00", o_clip, 16'h0000);
    drive(1'b1, 16'hFFFF);
    tick();
    chk("leak_ffff", o_leak, 16'hFFFF);
    drive(1'b1, 16'h8000);
    tick();
    chk("leak_8000", o_leak, 16'hE000);
    drive(1'b1, 16'h0000);
    tick();
    chk("leak_zero", o_leak, 16'h0000);

    hd = o_def;
    hc = o_clip;
    hl = o_leak;
    for (int i = 0; i < 40; i++) begin
      pe = 1'($urandom_range(0, 1));
      pd = 16'($urandom);
      drive(pe, pd);
      tick();
      chk("rnd_fdef", {15'b0, f_def}, {15'b0, pe});
      chk("rnd_fclip", {15'b0, f_clip}, {15'b0, pe});
      chk("rnd_fleak", {15'b0, f_leak}, {15'b0, pe});
      if (pe) begin
        hd = model(0, pd);
        hc = model(1, pd);
        hl = model(2, pd);
      end
      chk("rnd_odef", o_def, hd);
      chk("rnd_oclip", o_clip, hc);
      chk("rnd_oleak", o_leak, hl);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
